// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one physical memory port between the
// I-side fetch path and the D-side access path, with registered command and response.
module mem_arbiter #(
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_read,
  input  logic [15:0]           i_addr,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [15:0]           d_addr,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [15:0]           pmem_addr,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);
  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, RESP} state_t;
  state_t state, state_n;
  logic last_d, d_req, grant, pick_d, done;
  always_comb begin
    d_req = d_read | d_write;
    grant = (state == IDLE) && (i_read || d_req);
    pick_d = d_req && (!i_read || !last_d);
    done = ((state == I_BUSY) || (state == D_BUSY)) && pmem_resp;
    state_n = grant ? (pick_d ? D_BUSY : I_BUSY) : done ? RESP : (state == RESP) ? IDLE : state;
  end
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  // last_d resets to D so the first simultaneous request goes to the I side
  always_ff @(posedge clk) begin
    if (reset) begin
      last_d <= 1'b1;
      i_resp <= 1'b0;
      d_resp <= 1'b0;
      pmem_read <= 1'b0;
      pmem_write <= 1'b0;
      pmem_addr <= '0;
      pmem_wdata <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      i_resp <= done && (state == I_BUSY);
      d_resp <= done && (state == D_BUSY);
      if (grant) begin
        last_d <= pick_d;
        pmem_addr <= pick_d ? d_addr : i_addr;
        pmem_write <= pick_d && d_write;
        pmem_read <= !(pick_d && d_write);
        if (pick_d) pmem_wdata <= d_wdata;
      end else if (done) begin
        pmem_read <= 1'b0;
        pmem_write <= 1'b0;
      end
      if (done && (state == I_BUSY)) i_rdata <= pmem_rdata;
      if (done && (state == D_BUSY)) d_rdata <= pmem_rdata;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter with a transaction-level grant model.
module tb_mem_arbiter;
  localparam int W = 128;
  logic clk = 1'b0, reset = 1'b1;
  logic i_read = 1'b0, d_read = 1'b0, d_write = 1'b0, pmem_resp = 1'b0;
  logic [15:0] i_addr = '0, d_addr = '0;
  logic [W-1:0] d_wdata = '0, pmem_rdata = '0;
  logic [W-1:0] i_rdata, d_rdata, pmem_wdata;
  logic i_resp, d_resp, pmem_read, pmem_write;
  logic [15:0] pmem_addr;

  always #5 clk = ~clk;

  mem_arbiter #(.LINE_WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  typedef struct { logic [15:0] addr; logic wr; logic [W-1:0] wdata; int cyc; } cmd_t;
  typedef struct { logic side; logic [W-1:0] data; int cyc; } rsp_t;
  cmd_t cmd_q[$];
  rsp_t rsp_q[$];
  int tests = 0, fails = 0, cyc = 0, n_resp = 0;
  logic m_last_d = 1'b1, m_busy = 1'b0, m_side = 1'b0;
  int m_idle_at = 0;
  int i_auto = 0, d_auto = 0, lat_fixed = 0, mem_age = 0, mem_lat = 1;
  logic stray = 1'b0, cont = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bad(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got event expected none (cycle %0d)", name, cyc);
  endtask

  function automatic logic [W-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference model: one grant at a time, the other side wins ties if it was not served last;
  // the port is free again two cycles after memory completes, and one cycle after reset.
  task automatic model_edge();
    if (reset) begin
      m_busy = 1'b0;
      m_last_d = 1'b1;
      m_idle_at = cyc + 1;
      cmd_q.delete();
      rsp_q.delete();
    end else if (m_busy && pmem_resp) begin
      rsp_q.push_back('{m_side, pmem_rdata, cyc});
      m_busy = 1'b0;
      m_idle_at = cyc + 2;
    end else if (!m_busy && cyc >= m_idle_at && (i_read || d_read || d_write)) begin
      m_side = (d_read || d_write) && !(i_read && m_last_d);
      m_last_d = m_side;
      m_busy = 1'b1;
      if (m_side) cmd_q.push_back('{d_addr, d_write, d_wdata, cyc});
      else cmd_q.push_back('{i_addr, 1'b0, '0, cyc});
    end
  endtask

  task automatic drive();
    if (!reset && (pmem_read || pmem_write)) begin
      if (mem_age == 0) mem_lat = lat_fixed > 0 ? lat_fixed : int'($urandom_range(1, 4));
      mem_age++;
      pmem_resp = mem_age >= mem_lat;
      if (pmem_resp) mem_age = 0;
    end else begin
      mem_age = 0;
      pmem_resp = stray && ($urandom_range(0, 3) == 0);
    end
    pmem_rdata = rnd_line();
    if (i_read && i_resp) i_read = 1'b0;
    else if (!i_read && i_auto > 0 && $urandom_range(1, i_auto) == 1) begin
      i_read = 1'b1;
      i_addr = 16'($urandom);
    end
    if ((d_read || d_write) && d_resp) begin
      d_read = 1'b0;
      d_write = 1'b0;
    end else if (!(d_read || d_write) && d_auto > 0 && $urandom_range(1, d_auto) == 1) begin
      int op = int'($urandom_range(0, 2));
      d_read = op != 1;
      d_write = op != 0;
      d_addr = 16'($urandom);
      d_wdata = rnd_line();
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    drive();
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && (i_read || d_read || d_write || m_busy || cmd_q.size() > 0 || rsp_q.size() > 0); k++) step();
    if (i_read || d_read || d_write || m_busy) bad("drain_timeout");
  endtask

  logic cmd_act = 1'b0, have_prev = 1'b0, prev_side = 1'b0;
  int prev_cyc = 0;
  cmd_t cur;
  rsp_t r;
  always @(negedge clk) begin
    if (pmem_read || pmem_write) begin
      if (!cmd_act) begin
        cmd_act = 1'b1;
        if (cmd_q.size() == 0) begin
          bad("cmd_unexpected");
          cur = '{pmem_addr, pmem_write, pmem_wdata, cyc};
        end else begin
          cur = cmd_q.pop_front();
          chk("cmd_cycle", W'(cyc), W'(cur.cyc));
          chk("cmd_addr", W'(pmem_addr), W'(cur.addr));
          chk("cmd_write", W'(pmem_write), W'(cur.wr));
          chk("cmd_read", W'(pmem_read), W'(!cur.wr));
          if (cur.wr) chk("cmd_wdata", pmem_wdata, cur.wdata);
        end
      end else begin
        chk("hold_addr", W'(pmem_addr), W'(cur.addr));
        chk("hold_op", W'({pmem_read, pmem_write}), W'({!cur.wr, cur.wr}));
        if (cur.wr) chk("hold_wdata", pmem_wdata, cur.wdata);
      end
    end else cmd_act = 1'b0;
    if (!cont) have_prev = 1'b0;
    if (i_resp || d_resp) begin
      n_resp++;
      if (rsp_q.size() == 0) bad("resp_unexpected");
      else begin
        r = rsp_q.pop_front();
        chk("resp_cycle", W'(cyc), W'(r.cyc));
        chk("resp_i", W'(i_resp), W'(!r.side));
        chk("resp_d", W'(d_resp), W'(r.side));
        chk("resp_data", r.side ? d_rdata : i_rdata, r.data);
      end
      if (cont) begin
        if (have_prev) begin
          chk("cont_alternate", W'(d_resp), W'(!prev_side));
          chk("cont_period", W'(cyc - prev_cyc), W'(3));
        end
        have_prev = 1'b1;
        prev_side = d_resp;
        prev_cyc = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    repeat (3) step();
    @(negedge clk);
    chk("rst_i_resp", W'(i_resp), '0);
    chk("rst_d_resp", W'(d_resp), '0);
    chk("rst_pmem_read", W'(pmem_read), '0);
    chk("rst_pmem_write", W'(pmem_write), '0);
    chk("rst_pmem_addr", W'(pmem_addr), '0);
    chk("rst_pmem_wdata", pmem_wdata, '0);
    chk("rst_i_rdata", i_rdata, '0);
    chk("rst_d_rdata", d_rdata, '0);
    reset = 1'b0;
    lat_fixed = 3;
    i_addr = 16'h1000;
    i_read = 1'b1;
    drain();
    lat_fixed = 2;
    d_addr = 16'h2040;
    d_wdata = 128'hDEAD0123456789ABCDEF01234567BEEF;
    d_write = 1'b1;
    drain();
    reset = 1'b1;
    step();
    reset = 1'b0;
    lat_fixed = 1;
    i_addr = 16'h0100;
    i_read = 1'b1;
    d_addr = 16'h0200;
    d_read = 1'b1;
    drain();
    i_addr = 16'h0300;
    i_read = 1'b1;
    drain();
    i_addr = 16'h0400;
    i_read = 1'b1;
    d_addr = 16'h0500;
    d_read = 1'b1;
    drain();
    lat_fixed = 20;
    d_addr = 16'h3000;
    d_wdata = rnd_line();
    d_write = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("busy_write", W'(pmem_write), W'(1));
    reset = 1'b1;
    d_write = 1'b0;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("abort_write", W'(pmem_write), '0);
    chk("abort_read", W'(pmem_read), '0);
    chk("abort_addr", W'(pmem_addr), '0);
    lat_fixed = 0;
    repeat (25) step();
    stray = 1'b1;
    repeat (20) step();
    stray = 1'b0;
    step();
    @(negedge clk);
    chk("stray_idle_read", W'(pmem_read), '0);
    lat_fixed = 1;
    cont = 1'b1;
    start = n_resp;
    i_auto = 1;
    d_auto = 1;
    for (int k = 0; k < 300 && n_resp < start + 20; k++) step();
    if (n_resp < start + 20) bad("cont_timeout");
    i_auto = 0;
    d_auto = 0;
    cont = 1'b0;
    drain();
    lat_fixed = 0;
    stray = 1'b1;
    i_auto = 3;
    d_auto = 3;
    repeat (500) step();
    i_auto = 0;
    d_auto = 0;
    stray = 1'b0;
    drain();
    repeat (3) step();
    if (cmd_q.size() > 0 || rsp_q.size() > 0) bad("scoreboard_leftover");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
